bcd_counter_seg_mux: RTL and testbench

Parametrised multi-digit BCD up/down counter with time-multiplexed 7-segment display drive. Two internal prescalers generate the count and digit-scan ticks from CLK, and the block drives one shared segment bus plus an active-low digit-select bus. It is the general successor to the fixed 3-digit up-counter display used on the board, and adds configurable digit count, direction, enable, synchronous clear and carry/borrow output. All logic runs in the CLK domain; no derived clocks.

---
 rtl/bcd_counter_seg_mux_pkg.sv | 26 ++
 rtl/bcd_counter_seg_mux_seg7_decoder.sv | 29 ++
 rtl/bcd_counter_seg_mux.sv | 147 ++++++++++++++
 tb/tb_bcd_counter_seg_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_seg_mux_pkg.sv
// Shared constants and types for the BCD counter / 7-segment scan block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_counter_seg_mux_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Segment patterns, active-high, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit-select idle value (no digit driven); sliced to the bus width
    // at the point of use, so select buses up to 64 bits are supported.
    localparam logic [63:0] SEL_IDLE = '1;

endpackage

// File: rtl/bcd_counter_seg_mux_seg7_decoder.sv
// BCD digit to 7-segment pattern decoder; codes 10..15 decode to blank.
// Latency: combinational.
// Backpressure: none.
module seg7_decoder
    import bcd_counter_seg_mux_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_seg_mux.sv
// Multi-digit BCD up/down counter with time-multiplexed 7-segment drive; LZ_BLANK_EN enables leading-zero blanking.
// Latency: count step visible one edge after count_tick; SEG_C/SEG_SEL registered one cycle after the scan index.
// Backpressure: none; free-running, EN only freezes the count.
module bcd_counter_seg_mux
    import bcd_counter_seg_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SEL_WIDTH  = 8,
    parameter int COUNT_DIV  = 2500000,
    parameter int SCAN_DIV   = 25000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 UP,
    input  logic                 CLR,
    output logic [6:0]           SEG_C,
    output logic [SEL_WIDTH-1:0] SEG_SEL,
    output logic                 CARRY
);

    localparam int CW = $clog2(COUNT_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SEL_WIDTH-1:0] SEL_OFF = SEL_IDLE[SEL_WIDTH-1:0];
    localparam logic [SEL_WIDTH-1:0] SEL_RST = SEL_OFF & ~SEL_WIDTH'(1);

    logic [CW-1:0]   count_pre;
    logic [SW-1:0]   scan_pre;
    logic            count_tick;
    logic            scan_tick;
    logic            step_en;
    logic [IW-1:0]   scan_idx;
    bcd_t            digit [NUM_DIGITS];
    logic [NUM_DIGITS:0] nine_below;
    logic [NUM_DIGITS:0] zero_below;
    bcd_t            cur_digit;
    logic            blank;
    logic [6:0]      dec_seg;
    logic [SEL_WIDTH-1:0] sel_nxt;

    assign count_tick = (count_pre == CW'(COUNT_DIV - 1));
    assign scan_tick  = (scan_pre == SW'(SCAN_DIV - 1));
    assign step_en    = count_tick & EN;

    // Count prescaler: 0..COUNT_DIV-1, unaffected by CLR
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)           count_pre <= '0;
        else if (count_tick) count_pre <= '0;
        else                 count_pre <= count_pre + 1'b1;
    end

    // Scan prescaler: 0..SCAN_DIV-1
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          scan_pre <= '0;
        else if (scan_tick) scan_pre <= '0;
        else                scan_pre <= scan_pre + 1'b1;
    end

    // Ripple conditions: digit i steps only when every lower digit wraps
    always_comb begin
        nine_below    = '0;
        zero_below    = '0;
        nine_below[0] = 1'b1;
        zero_below[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nine_below[i+1] = nine_below[i] & (digit[i] == 4'd9);
            zero_below[i+1] = zero_below[i] & (digit[i] == 4'd0);
        end
    end

    // BCD digit chain
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_t q;
        assign digit[i] = q;

        // One digit: clear wins over a step, otherwise hold
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                q <= '0;
            end else if (CLR) begin
                q <= '0;
            end else if (step_en) begin
                if (UP) begin
                    if (nine_below[i]) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
                end else begin
                    if (zero_below[i]) q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
                end
            end
        end
    end

    // Wrap pulse, aligned with the wrapped digit values
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) CARRY <= 1'b0;
        else       CARRY <= ~CLR & step_en &
                            (UP ? nine_below[NUM_DIGITS] : zero_below[NUM_DIGITS]);
    end

    // Scan index walks 0..NUM_DIGITS-1
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            scan_idx <= '0;
        else if (scan_tick)
            scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end

    // Select the scanned digit, its select pattern and its blanking state
    always_comb begin
        cur_digit = '0;
        sel_nxt   = SEL_OFF;
        blank     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_digit  = digit[i];
                sel_nxt[i] = 1'b0;
            end
        end
`ifdef LZ_BLANK_EN
        // Blank when this and every higher digit are zero; digit 0 always shows
        blank = (scan_idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(scan_idx) && digit[i] != 4'd0) blank = 1'b0;
        end
`else
        blank = 1'b0;
`endif
    end

    seg7_decoder u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Select and pattern register together so they never disagree
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_SEL <= SEL_RST;
            SEG_C   <= SEG_0;
        end else begin
            SEG_SEL <= sel_nxt;
            SEG_C   <= blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_bcd_counter_seg_mux.sv
// Randomised and directed bench for bcd_counter_seg_mux against an integer-valued model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_counter_seg_mux;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic       UP;
    logic       CLR;
    logic [6:0] SEG_C;
    logic [7:0] SEG_SEL;
    logic       CARRY;

    int n_tests = 0;
    int n_fail  = 0;
    int n_carry = 0;

    // Model state: counter value as a plain integer, prescaler phases, scan position
    int m_val, m_cpre, m_spre, m_idx;

    bcd_counter_seg_mux #(
        .NUM_DIGITS (3),
        .SEL_WIDTH  (8),
        .COUNT_DIV  (4),
        .SCAN_DIV   (2)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .UP      (UP),
        .CLR     (CLR),
        .SEG_C   (SEG_C),
        .SEG_SEL (SEG_SEL),
        .CARRY   (CARRY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
            4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
            8: return 7'h7f;  9: return 7'h6f;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int p10(input int k);
        int r = 1;
        for (int j = 0; j < k; j++) r = r * 10;
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_cpre = 0; m_spre = 0; m_idx = 0;
    endtask

    // One clock: predict outputs from the pre-edge state and inputs, then compare
    task automatic step();
        logic [7:0] e_sel;
        logic [6:0] e_seg;
        logic       e_car;
        int         d;
        e_sel = 8'hFF & ~(8'd1 << m_idx);
        d     = (m_val / p10(m_idx)) % 10;
        e_seg = seg_of(d);
`ifdef LZ_BLANK_EN
        if (m_idx > 0 && m_val < p10(m_idx)) e_seg = 7'h00;
`endif
        e_car = 1'b0;
        if (CLR) begin
            m_val = 0;
        end else if (m_cpre == 3 && EN) begin
            if (UP) begin
                if (m_val == 999) begin m_val = 0;   e_car = 1'b1; end
                else              m_val = m_val + 1;
            end else begin
                if (m_val == 0)   begin m_val = 999; e_car = 1'b1; end
                else              m_val = m_val - 1;
            end
        end
        m_cpre = (m_cpre + 1) % 4;
        if (m_spre == 1) m_idx = (m_idx + 1) % 3;
        m_spre = (m_spre + 1) % 2;
        @(posedge CLK);
        #1;
        check("seg_sel", SEG_SEL, e_sel);
        check("seg_c",   SEG_C,   e_seg);
        check("carry",   CARRY,   e_car);
        if (CARRY) n_carry++;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_val != target && guard < 5000) begin
            step();
            guard++;
        end
        check("run_to_bound", (guard < 5000), 1'b1);
    endtask

    initial begin
        RESET = 1'b1; EN = 1'b0; UP = 1'b1; CLR = 1'b0;
        model_reset();
        #1;
        check("rst_sel",   SEG_SEL, 8'hFE);
        check("rst_seg",   SEG_C,   7'h3f);
        check("rst_carry", CARRY,   1'b0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Full up wrap: 1000 ticks from 000, exactly one carry
        EN = 1'b1; UP = 1'b1; n_carry = 0;
        repeat (4000) step();
        check("up_wrap_carries", n_carry, 1);

        // Down wrap 000 -> 999 with carry, then 998 without
        UP = 1'b0; n_carry = 0;
        repeat (4) step();
        check("down_wrap_carry", n_carry, 1);
        repeat (4) step();
        check("down_998_no_carry", n_carry, 1);

        // Back up to 999 then clear exactly on a count tick
        UP = 1'b1;
        run_to(999);
        while (m_cpre != 3) step();
        CLR = 1'b1; n_carry = 0;
        step();
        CLR = 1'b0;
        check("clr_on_tick_carry", n_carry, 0);
        repeat (8) step();

        // Freeze: scanning keeps going, value must not move
        EN = 1'b0;
        repeat (20) step();

        // Scan consistency on 472
        CLR = 1'b1; step(); CLR = 1'b0;
        EN = 1'b1; UP = 1'b1;
        run_to(472);
        EN = 1'b0;
        repeat (12) step();

        // Leading-zero cases: 007 and 000
        CLR = 1'b1; step(); CLR = 1'b0;
        EN = 1'b1;
        run_to(7);
        EN = 1'b0;
        repeat (12) step();
        CLR = 1'b1; step(); CLR = 1'b0;
        repeat (12) step();

        // Random control traffic
        for (int k = 0; k < 1500; k++) begin
            EN  = ($urandom_range(0, 3) != 0);
            UP  = $urandom_range(0, 1);
            CLR = ($urandom_range(0, 39) == 0);
            step();
        end
        CLR = 1'b0;

        // Asynchronous reset mid-cycle
        EN = 1'b1; UP = 1'b1;
        #3;
        RESET = 1'b1;
        #1;
        check("arst_sel",   SEG_SEL, 8'hFE);
        check("arst_seg",   SEG_C,   7'h3f);
        check("arst_carry", CARRY,   1'b0);
        @(posedge CLK); #1;
        check("arst_hold_sel", SEG_SEL, 8'hFE);
        RESET = 1'b0;
        model_reset();
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
